muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers for the MIPS core.
- Executes mult, multu, div and divu over multiple cycles, and services mthi/mtlo writes.
- Parametrised in datapath width.
- Sits beside the main ALU. The controller starts an operation, stalls on busy, and reads hi/lo for mfhi/mflo.

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// It runs a shift-add multiply or a restoring divide on operand magnitudes, one bit per clock.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, a_orig_q;
    logic               neg_q, rneg_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH:0]   shl;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // op[0]=0 selects the signed variants; magnitudes are taken only for those.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_abs = a_neg ? -a : a;
        b_abs = b_neg ? -b : b;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum    = '0;
        trial  = '0;
        shl    = '0;
        acc_d  = acc_q;
        if (!op_q[1]) begin
            sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
        end else begin
            shl   = {acc_q[2*WIDTH-1:0], 1'b0};
            trial = shl[2*WIDTH:WIDTH] - {1'b0, opnd_q};
            acc_d = trial[WIDTH] ? shl : {trial, shl[WIDTH-1:1], 1'b1};
        end

        prod = acc_d[2*WIDTH-1:0];
        quo  = acc_d[WIDTH-1:0];
        rem  = acc_d[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            prod   = neg_q ? -prod : prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (opnd_q == '0) begin
            res_hi = a_orig_q;
            res_lo = '1;
        end else begin
            res_hi = rneg_q ? -rem : rem;
            res_lo = neg_q  ? -quo : quo;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        a_orig_q <= a;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        opnd_q   <= op[1] ? b_abs : a_abs;
                        acc_q    <= {{(WIDTH+1){1'b0}}, (op[1] ? a_abs : b_abs)};
                        cnt_q    <= CNT_W'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit instance for the main vectors, 8-bit instance for width scaling.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_pass   = 0;
    int lat, bcnt;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation on the 32-bit unit; returns cycles to done and busy-high cycles.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int l, output int bc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        bc = busy ? 1 : 0;
        l  = 0;
        while (!done && l < 100) begin
            @(posedge clk); #1;
            l++;
            if (busy) bc++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk); reset = 1'b0;

        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        check("multu_lat", lat, 32);
        check("multu_busy", bcnt, 32);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        @(posedge clk); #1;
        check("done_pulse", done, 0);

        do_op(MULT, 32'hFFFFFFFD, 32'd7, lat, bcnt);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);
        // Back-to-back: this start lands on the done cycle of the previous op.
        do_op(MULT, 32'h80000000, 32'h80000000, lat, bcnt);
        check("mult_min_lat", lat, 32);
        check("mult_min_hi", hi, 32'h40000000);
        check("mult_min_lo", lo, 32'h00000000);

        do_op(DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        do_op(DIVU, 32'd100, 32'd7, lat, bcnt);
        check("divu_lo", lo, 32'h0000000E);
        check("divu_hi", hi, 32'h00000002);
        do_op(DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'h00000001);

        do_op(DIVU, 32'h1234, 32'h0, lat, bcnt);
        check("divz_lat", lat, 32);
        check("divz_lo", lo, 32'hFFFFFFFF);
        check("divz_hi", hi, 32'h00001234);
        do_op(DIV, 32'hFFFFFF00, 32'h0, lat, bcnt);
        check("divz_s_lo", lo, 32'hFFFFFFFF);
        check("divz_s_hi", hi, 32'hFFFFFF00);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h00000000);

        // multu 3*5 with an ignored start and mthi in the middle of the run.
        @(negedge clk);
        op = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        op = DIVU; a = 32'd9; b = 32'd2; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        lat++;
        start = 1'b0; hi_we = 1'b0;
        check("busy_ign", busy, 1);
        check("hi_busy_we", hi, 32'h0);
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("ign_lat", lat, 32);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd15);

        @(negedge clk); lo_we = 1'b1; wdata = 32'hCAFE;
        @(posedge clk); #1; lo_we = 1'b0;
        check("mtlo", lo, 32'h0000CAFE);
        check("mtlo_hi", hi, 32'h0);
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11112222;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", hi, 32'h11112222);
        check("mthilo_lo", lo, 32'h11112222);

        @(negedge clk);
        op = MULTU; a = 32'd1; b = 32'd1; start = 1'b1; hi_we = 1'b1; wdata = 32'hBEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("start_wins_busy", busy, 1);
        check("start_wins_hi", hi, 32'h11112222);
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("one_hi", hi, 32'h0);
        check("one_lo", lo, 32'h1);

        // Asynchronous reset partway through a divide.
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk); reset = 1'b0;

        do_op(MULTU, 32'd6, 32'd7, lat, bcnt);
        check("post_rst_lat", lat, 32);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);

        // 8-bit instance.
        @(negedge clk);
        op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("w8_lat", lat, 8);
        check("w8_hi", hi8, 8'hFE);
        check("w8_lo", lo8, 8'h01);
        @(negedge clk);
        op8 = DIV; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("w8_ovf_lo", lo8, 8'h80);
        check("w8_ovf_hi", hi8, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
